// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between requesters, the shared multiplier
// and the result consumer.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = A_WIDTH + B_WIDTH
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][A_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][B_WIDTH-1:0] req_b;
  logic                            res_valid;
  logic                            res_ready;
  logic [OUT_WIDTH-1:0]            res_data;
  logic [ID_WIDTH-1:0]             res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter in front of one shared signed multiplier,
// two-stage pipeline (operands, scaled product).
module mult_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = A_WIDTH + B_WIDTH,
  parameter int OUT_SCALE = 0
) (
  input logic                 clk,
  input logic                 arst_n_in,
  mult_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = A_WIDTH + B_WIDTH;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] ptr_next;
  logic           found;
  logic           any_req;
  logic           s1_can;
  logic           s2_load;
  logic           accept;

  logic                        s1_valid;
  logic signed [A_WIDTH-1:0]   s1_a;
  logic signed [B_WIDTH-1:0]   s1_b;
  logic [IDW-1:0]              s1_id;
  logic                        s2_valid;
  logic signed [OUT_WIDTH-1:0] s2_data;
  logic [IDW-1:0]              s2_id;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // Lowest valid index at or above rr_ptr, else lowest overall.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && i >= int'(rr_ptr)) begin
        gnt   = IDW'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (bus.req_valid[i]) gnt = IDW'(i);
      end
    end
  end

  assign any_req = |bus.req_valid;
  assign s2_load = !s2_valid || bus.res_ready;
  assign s1_can  = !s1_valid || s2_load;
  assign accept  = arst_n_in && any_req && s1_can;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt] = 1'b1;
  end

  assign ptr_next = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

  assign prod    = PW'(s1_a) * PW'(s1_b);
  assign shifted = prod >>> OUT_SCALE;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      rr_ptr   <= ptr_next;
      s1_valid <= 1'b1;
      s1_a     <= bus.req_a[gnt];
      s1_b     <= bus.req_b[gnt];
      s1_id    <= gnt;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Data only moves with a real result so idle outputs hold.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= OUT_WIDTH'(shifted);
        s2_id   <= s1_id;
      end
    end
  end

  assign bus.res_valid = s2_valid;
  assign bus.res_data  = s2_data;
  assign bus.res_id    = s2_id;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: scoreboard of accepted operands
// against results, plus per-scenario inline checks.
module tb_mult_share_arbiter;
  logic clk;
  logic rst_n;

  mult_share_arbiter_if bus0 ();
  mult_share_arbiter_if bus1 ();

  mult_share_arbiter dut0 (
    .clk       (clk),
    .arst_n_in (rst_n),
    .bus       (bus0)
  );

  mult_share_arbiter #(.OUT_SCALE(4)) dut1 (
    .clk       (clk),
    .arst_n_in (rst_n),
    .bus       (bus1)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   total;
  int   passed;
  int   accepts;
  int   mptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(logic [7:0] a, logic [7:0] b,
                                        int sc);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p >>> sc;
  endfunction

  function automatic int model_gnt(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr = 0;
    end else begin
      if (bus0.req_ready != 4'b0) begin
        int g;
        g = model_gnt(bus0.req_valid, mptr);
        total++;
        if (bus0.req_ready !== 4'(1 << g))
          $display("FAIL grant: got %b want %b",
                   bus0.req_ready, 4'(1 << g));
        else passed++;
        q.push_back({2'(g), model(bus0.req_a[g], bus0.req_b[g], 0)});
        accepts++;
        mptr = (g + 1) % 4;
      end
      if (bus0.res_valid && bus0.res_ready) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_result: got id %0d data %h want none",
                   bus0.res_id, bus0.res_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus0.res_data !== e.data || bus0.res_id !== e.id)
            $display("FAIL result: got id %0d data %h want id %0d data %h",
                     bus0.res_id, bus0.res_data, e.id, e.data);
          else passed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.req_valid = '0;
    bus0.req_a     = '0;
    bus0.req_b     = '0;
    bus0.res_ready = 1'b0;
    bus1.req_valid = '0;
    bus1.req_a     = '0;
    bus1.req_b     = '0;
    bus1.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      bus0.req_a[i] = 8'($urandom);
      bus0.req_b[i] = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus0.req_valid = 4'hF;
    bus0.res_ready = 1'b1;
    #2;
    total++;
    if (bus0.req_ready !== 4'b0 || bus0.res_valid !== 1'b0)
      $display("FAIL reset_ctrl: got ready %b valid %b want 0000 0",
               bus0.req_ready, bus0.res_valid);
    else passed++;
    total++;
    if (bus0.res_data !== 16'h0 || bus0.res_id !== 2'd0)
      $display("FAIL reset_data: got %h id %0d want 0000 id 0",
               bus0.res_data, bus0.res_id);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 4'b0)
      $display("FAIL reset_noaccept: got %b want 0000", bus0.req_ready);
    else passed++;
    step();
    bus0.req_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus0.res_ready    = 1'b1;
    bus0.req_valid    = 4'b0001;
    bus0.req_a[0]     = 8'hFD;
    bus0.req_b[0]     = 8'd5;
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 4'b0001)
      $display("FAIL single_ready: got %b want 0001", bus0.req_ready);
    else passed++;
    step();
    bus0.req_valid = '0;
    @(negedge clk);
    total++;
    if (bus0.res_valid !== 1'b0)
      $display("FAIL single_early: got %b want 0", bus0.res_valid);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (bus0.res_valid !== 1'b1 || bus0.res_data !== 16'hFFF1 ||
        bus0.res_id !== 2'd0)
      $display("FAIL single_result: got v%b %h id %0d want v1 fff1 id 0",
               bus0.res_valid, bus0.res_data, bus0.res_id);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (bus0.res_valid !== 1'b0 || bus0.res_data !== 16'hFFF1)
      $display("FAIL single_hold: got v%b %h want v0 fff1",
               bus0.res_valid, bus0.res_data);
    else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus0.res_ready = 1'b1;
    bus0.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      @(negedge clk);
      total++;
      if (bus0.req_ready !== 4'(1 << (k % 4)))
        $display("FAIL rr_order: cycle %0d got %b want %b",
                 k, bus0.req_ready, 4'(1 << (k % 4)));
      else passed++;
      step();
    end
    bus0.req_valid = '0;
    repeat (4) step();
    total++;
    if (q.size() != 0)
      $display("FAIL rr_drain: got %0d pending want 0", q.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [15:0] held;
    logic        stable;
    do_reset();
    accepts        = 0;
    held           = '0;
    stable         = 1'b1;
    bus0.res_ready = 1'b0;
    bus0.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      @(negedge clk);
      if (k == 2) held = bus0.res_data;
      if (k >= 2) begin
        if (bus0.req_ready !== 4'b0 || bus0.res_valid !== 1'b1 ||
            bus0.res_data !== held)
          stable = 1'b0;
      end
      step();
    end
    total++;
    if (accepts != 2)
      $display("FAIL stall_accepts: got %0d want 2", accepts);
    else passed++;
    total++;
    if (stable !== 1'b1)
      $display("FAIL stall_hold: got unstable want stable");
    else passed++;
    bus0.req_valid = '0;
    bus0.res_ready = 1'b1;
    for (int k = 0; k < 20 && (q.size() != 0 || bus0.res_valid); k++)
      step();
    total++;
    if (q.size() != 0 || bus0.res_valid !== 1'b0)
      $display("FAIL stall_drain: got %0d pending valid %b want 0 0",
               q.size(), bus0.res_valid);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    bus0.res_ready = 1'b1;
    bus0.req_valid = 4'b0010;
    rand_ops();
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 4'b0010)
      $display("FAIL wrap_first: got %b want 0010", bus0.req_ready);
    else passed++;
    step();
    rand_ops();
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 4'b0010)
      $display("FAIL wrap_grant: got %b want 0010", bus0.req_ready);
    else passed++;
    step();
    bus0.req_valid = 4'hF;
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 4'b0100)
      $display("FAIL wrap_ptr: got %b want 0100", bus0.req_ready);
    else passed++;
    step();
    bus0.req_valid = '0;
    repeat (4) step();
  endtask

  task automatic test_scale();
    bit seen;
    seen           = 1'b0;
    bus1.res_ready = 1'b1;
    bus1.req_valid = 4'b0001;
    bus1.req_a[0]  = 8'h80;
    bus1.req_b[0]  = 8'h7F;
    step();
    bus1.req_valid = '0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus1.res_valid === 1'b1) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen)
      $display("FAIL scale_timeout: got no result want one");
    else if (bus1.res_data !== 16'hFC08 || bus1.res_id !== 2'd0)
      $display("FAIL scale_data: got %h id %0d want fc08 id 0",
               bus1.res_data, bus1.res_id);
    else passed++;
    bus1.res_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic quiet;
    do_reset();
    bus0.res_ready = 1'b0;
    bus0.req_valid = 4'hF;
    rand_ops();
    repeat (3) step();
    @(negedge clk);
    total++;
    if (bus0.res_valid !== 1'b1 || bus0.req_ready !== 4'b0)
      $display("FAIL mid_full: got v%b ready %b want v1 0000",
               bus0.res_valid, bus0.req_ready);
    else passed++;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus0.res_valid !== 1'b0 || bus0.req_ready !== 4'b0 ||
        bus0.res_data !== 16'h0)
      $display("FAIL mid_async: got v%b ready %b %h want v0 0000 0000",
               bus0.res_valid, bus0.req_ready, bus0.res_data);
    else passed++;
    step();
    step();
    bus0.req_valid = '0;
    bus0.res_ready = 1'b1;
    rst_n          = 1'b1;
    quiet          = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus0.res_valid !== 1'b0) quiet = 1'b0;
      step();
    end
    total++;
    if (quiet !== 1'b1)
      $display("FAIL mid_stale: got stale result want none");
    else passed++;
    bus0.req_valid = 4'b1000;
    rand_ops();
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 4'b1000)
      $display("FAIL mid_resume: got %b want 1000", bus0.req_ready);
    else passed++;
    step();
    bus0.req_valid = '0;
    repeat (4) step();
    total++;
    if (q.size() != 0)
      $display("FAIL mid_drain: got %0d pending want 0", q.size());
    else passed++;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    accepts = 0;
    mptr    = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_scale();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
